xpb_table_gen: RTL

Sequential generator for the per-digit reduction lookup tables used by the modular squaring datapath. Given a modulus M and a base value B = 2^k mod M, it computes the 32 entries j·B mod M (j = 0..31) by iterated modular addition. It streams each entry out through a one-entry-per-write port into the table storage, which the squarer's 5-bit-digit xpb lookup then reads. Running it once per table lets the team regenerate tables for a new modulus at run time instead of hard-coding constants.

---
 rtl/xpb_table_gen.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/xpb_table_gen.sv
`default_nettype none
// ============================================================================
// Module   : xpb_table_gen
// Brief    : Builds the 32-entry j*B mod M reduction table by iterated modular
//            addition and streams one entry per write strobe.
// Revision : 1.0 - initial release
// ============================================================================
module xpb_table_gen #(
    parameter int WORD_LEN   = 1024,
    parameter int DIGIT_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [WORD_LEN-1:0]   modulus_i,
    input  logic [WORD_LEN-1:0]   base_i,
    output logic                  wr_en_o,
    output logic [DIGIT_BITS-1:0] wr_addr_o,
    output logic [WORD_LEN-1:0]   wr_data_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [DIGIT_BITS-1:0] c_last_idx = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_RED  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t                state_q,   state_d;
    logic [WORD_LEN-1:0]   mod_q,     mod_d;
    logic [WORD_LEN-1:0]   base_q,    base_d;
    logic [WORD_LEN-1:0]   acc_q,     acc_d;
    logic [WORD_LEN:0]     sum_q,     sum_d;
    logic [DIGIT_BITS-1:0] idx_q,     idx_d;
    logic                  wr_en_q,   wr_en_d;
    logic [DIGIT_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_LEN-1:0]   wr_data_q, wr_data_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;

    logic                  w_geq;
    logic [WORD_LEN-1:0]   w_red;

    // The subtraction is done at WORD_LEN bits: the carry bit of sum_q only
    // matters for the compare, and the truncated difference is identical.
    assign w_geq = (sum_q >= {1'b0, mod_q});
    assign w_red = w_geq ? (sum_q[WORD_LEN-1:0] - mod_q) : sum_q[WORD_LEN-1:0];

    always_comb begin
        state_d   = state_q;
        mod_d     = mod_q;
        base_d    = base_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        idx_d     = idx_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mod_d     = modulus_i;
                    base_d    = base_i;
                    acc_d     = '0;
                    idx_d     = DIGIT_BITS'(1);
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = '0;
                    busy_d    = 1'b1;
                    state_d   = S_ADD;
                end
            end
            S_ADD: begin
                sum_d   = {1'b0, acc_q} + {1'b0, base_q};
                state_d = S_RED;
            end
            S_RED: begin
                acc_d     = w_red;
                wr_en_d   = 1'b1;
                wr_addr_d = idx_q;
                wr_data_d = w_red;
                if (idx_q == c_last_idx) begin
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + DIGIT_BITS'(1);
                    state_d = S_ADD;
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mod_q     <= '0;
            base_q    <= '0;
            acc_q     <= '0;
            sum_q     <= '0;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mod_q     <= mod_d;
            base_q    <= base_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            idx_q     <= idx_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule
`default_nettype wire
